// File: rtl/hazard_unit.sv
// Pipeline hazard controller: load-use, branch redirect and data-memory stall handling.
// Outputs are combinational from the registered FSM state and the current inputs.
module hazard_unit #(
   parameter int BR_PENALTY  = 2,
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       IFID_Rs,
   input  logic [4:0]       IFID_Rt,
   input  logic [4:0]       IDEX_Rt,
   input  logic             IDEX_MemRead,
   input  logic             Branch_Taken,
   input  logic             Jump,
   input  logic             Mem_Req,
   input  logic             Mem_Ready,
   output logic             PC_Write,
   output logic             IFID_Write,
   output logic             IFID_Flush,
   output logic             IDEX_Bubble,
   output logic             Pipe_Hold,
   output logic [1:0]       State,
   output logic [CNT_W-1:0] Stall_Count,
   output logic             Mem_Err
);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_REDIRECT = 2'd2
   } state_t;

   localparam logic [2:0]       RD_LOAD_V = 3'(BR_PENALTY - 1);
   localparam logic [7:0]       TIMEOUT_V = 8'(MEM_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_MAX_V = {CNT_W{1'b1}};

   state_t     state_r, state_nxt_s;
   logic [2:0] rd_cnt_r, rd_cnt_nxt_s;
   logic [7:0] wait_cnt_r, wait_cnt_nxt_s;
   logic [CNT_W-1:0] stall_cnt_r;
   logic       mem_err_r;

   logic mem_stall_s, load_use_s;
   logic pc_write_s, ifid_write_s, flush_s, bubble_s, hold_s;
   logic err_set_s, stall_inc_s;

   // Hazard conditions decoded from the current inputs
   always_comb begin
      mem_stall_s = Mem_Req && !Mem_Ready;
      load_use_s  = IDEX_MemRead && (IDEX_Rt != 5'd0) &&
                    ((IDEX_Rt == IFID_Rs) || (IDEX_Rt == IFID_Rt));
   end

   // Next-state and raw control outputs
   always_comb begin
      state_nxt_s    = state_r;
      rd_cnt_nxt_s   = rd_cnt_r;
      wait_cnt_nxt_s = wait_cnt_r;
      pc_write_s     = 1'b1;
      ifid_write_s   = 1'b1;
      flush_s        = 1'b0;
      bubble_s       = 1'b0;
      hold_s         = 1'b0;
      case (state_r)
         ST_RUN: begin
            if (mem_stall_s) begin
               pc_write_s     = 1'b0;
               ifid_write_s   = 1'b0;
               hold_s         = 1'b1;
               state_nxt_s    = ST_MEM_WAIT;
               wait_cnt_nxt_s = 8'd1;
            end else if (Branch_Taken) begin
               flush_s  = 1'b1;
               bubble_s = 1'b1;
               if (BR_PENALTY > 1) begin
                  state_nxt_s  = ST_REDIRECT;
                  rd_cnt_nxt_s = RD_LOAD_V;
               end else begin
                  state_nxt_s = ST_RUN;
               end
            end else if (load_use_s) begin
               pc_write_s   = 1'b0;
               ifid_write_s = 1'b0;
               bubble_s     = 1'b1;
            end else if (Jump) begin
               flush_s = 1'b1;
            end else begin
               state_nxt_s = ST_RUN;
            end
         end
         ST_MEM_WAIT: begin
            if (Mem_Ready) begin
               state_nxt_s    = ST_RUN;
               wait_cnt_nxt_s = 8'd0;
            end else begin
               pc_write_s     = 1'b0;
               ifid_write_s   = 1'b0;
               hold_s         = 1'b1;
               wait_cnt_nxt_s = (wait_cnt_r == 8'hFF) ? 8'hFF : wait_cnt_r + 8'd1;
            end
         end
         ST_REDIRECT: begin
            // a memory stall freezes the redirect sequence where it stands
            if (mem_stall_s) begin
               pc_write_s   = 1'b0;
               ifid_write_s = 1'b0;
               hold_s       = 1'b1;
            end else begin
               flush_s = 1'b1;
               if (rd_cnt_r <= 3'd1) begin
                  state_nxt_s  = ST_RUN;
                  rd_cnt_nxt_s = 3'd0;
               end else begin
                  rd_cnt_nxt_s = rd_cnt_r - 3'd1;
               end
            end
         end
         default: begin
            state_nxt_s    = ST_RUN;
            rd_cnt_nxt_s   = 3'd0;
            wait_cnt_nxt_s = 8'd0;
         end
      endcase
   end

   // Outputs forced to pass-through defaults while reset is asserted
   always_comb begin
      if (!rst_n) begin
         PC_Write    = 1'b1;
         IFID_Write  = 1'b1;
         IFID_Flush  = 1'b0;
         IDEX_Bubble = 1'b0;
         Pipe_Hold   = 1'b0;
      end else begin
         PC_Write    = pc_write_s;
         IFID_Write  = ifid_write_s;
         IFID_Flush  = flush_s;
         IDEX_Bubble = bubble_s;
         Pipe_Hold   = hold_s;
      end
   end

   // Timeout and lost-cycle qualifiers
   always_comb begin
      err_set_s   = (state_nxt_s == ST_MEM_WAIT) && (wait_cnt_nxt_s >= TIMEOUT_V);
      stall_inc_s = (!PC_Write || IFID_Flush) && (stall_cnt_r != CNT_MAX_V);
   end

   // State, counters and sticky error register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_RUN;
         rd_cnt_r    <= 3'd0;
         wait_cnt_r  <= 8'd0;
         stall_cnt_r <= {CNT_W{1'b0}};
         mem_err_r   <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         rd_cnt_r   <= rd_cnt_nxt_s;
         wait_cnt_r <= wait_cnt_nxt_s;
         if (stall_inc_s) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end
         if (err_set_s) begin
            mem_err_r <= 1'b1;
         end
      end
   end

   assign State       = state_r;
   assign Stall_Count = stall_cnt_r;
   assign Mem_Err     = mem_err_r;

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
module tb_hazard_unit;

   localparam int BR  = 2;
   localparam int TO  = 4;
   localparam int CW  = 6;
   localparam int CMAX = 63;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] IFID_Rs, IFID_Rt, IDEX_Rt;
   logic       IDEX_MemRead, Branch_Taken, Jump, Mem_Req, Mem_Ready;
   logic       PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, Pipe_Hold;
   logic [1:0] State;
   logic [CW-1:0] Stall_Count;
   logic       Mem_Err;

   int n_chk = 0;
   int n_err = 0;

   // model: mode 0 running, 1 waiting on memory, 2 redirecting
   int m_mode, m_left, m_waited, m_cnt;
   bit m_err;

   hazard_unit #(.BR_PENALTY(BR), .MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt), .IDEX_Rt(IDEX_Rt),
      .IDEX_MemRead(IDEX_MemRead), .Branch_Taken(Branch_Taken), .Jump(Jump),
      .Mem_Req(Mem_Req), .Mem_Ready(Mem_Ready),
      .PC_Write(PC_Write), .IFID_Write(IFID_Write), .IFID_Flush(IFID_Flush),
      .IDEX_Bubble(IDEX_Bubble), .Pipe_Hold(Pipe_Hold), .State(State),
      .Stall_Count(Stall_Count), .Mem_Err(Mem_Err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_left = 0; m_waited = 0; m_cnt = 0; m_err = 1'b0;
   endtask

   // Per-cycle comparison against the model, then advance the model for the coming edge
   initial begin
      bit e_pcw, e_ifw, e_fl, e_bub, e_hold, ms, lu;
      model_reset();
      forever begin
         @(negedge clk);
         ms = Mem_Req && !Mem_Ready;
         lu = IDEX_MemRead && IDEX_Rt != 5'd0 && (IDEX_Rt == IFID_Rs || IDEX_Rt == IFID_Rt);
         e_pcw = 1'b1; e_ifw = 1'b1; e_fl = 1'b0; e_bub = 1'b0; e_hold = 1'b0;
         if (rst_n) begin
            case (m_mode)
               0: begin
                  if (ms) begin e_pcw = 1'b0; e_ifw = 1'b0; e_hold = 1'b1; end
                  else if (Branch_Taken) begin e_fl = 1'b1; e_bub = 1'b1; end
                  else if (lu) begin e_pcw = 1'b0; e_ifw = 1'b0; e_bub = 1'b1; end
                  else if (Jump) e_fl = 1'b1;
               end
               1: if (!Mem_Ready) begin e_pcw = 1'b0; e_ifw = 1'b0; e_hold = 1'b1; end
               2: begin
                  if (ms) begin e_pcw = 1'b0; e_ifw = 1'b0; e_hold = 1'b1; end
                  else e_fl = 1'b1;
               end
               default: ;
            endcase
         end
         chk("pc_write", PC_Write, e_pcw);
         chk("ifid_write", IFID_Write, e_ifw);
         chk("ifid_flush", IFID_Flush, e_fl);
         chk("idex_bubble", IDEX_Bubble, e_bub);
         chk("pipe_hold", Pipe_Hold, e_hold);
         chk("state", State, m_mode);
         chk("stall_count", Stall_Count, m_cnt);
         chk("mem_err", Mem_Err, m_err);
         if (rst_n) begin
            if (!e_pcw || e_fl) m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
            case (m_mode)
               0: begin
                  if (ms) begin
                     m_mode = 1; m_waited = 1;
                     if (m_waited >= TO) m_err = 1'b1;
                  end else if (Branch_Taken && BR > 1) begin
                     m_mode = 2; m_left = BR - 1;
                  end
               end
               1: begin
                  if (Mem_Ready) m_mode = 0;
                  else begin
                     m_waited = (m_waited < 255) ? m_waited + 1 : 255;
                     if (m_waited >= TO) m_err = 1'b1;
                  end
               end
               2: begin
                  if (!ms) begin
                     m_left--;
                     if (m_left == 0) m_mode = 0;
                  end
               end
               default: m_mode = 0;
            endcase
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic mid();
      @(negedge clk); #1;
   endtask

   task automatic idle();
      IFID_Rs = 5'd0; IFID_Rt = 5'd0; IDEX_Rt = 5'd0; IDEX_MemRead = 1'b0;
      Branch_Taken = 1'b0; Jump = 1'b0; Mem_Req = 1'b0; Mem_Ready = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      mid();
      chk("rst_pcw", PC_Write, 1);
      chk("rst_state", State, 0);
      chk("rst_cnt", Stall_Count, 0);
      tick(); rst_n = 1'b1;

      // load-use hit, then same with IDEX_Rt = 0
      tick(); IDEX_MemRead = 1'b1; IDEX_Rt = 5'd5; IFID_Rs = 5'd5;
      mid(); chk("lu_pcw", PC_Write, 0); chk("lu_ifw", IFID_Write, 0); chk("lu_bub", IDEX_Bubble, 1);
      tick(); idle();
      mid(); chk("lu_after_bub", IDEX_Bubble, 0); chk("lu_cnt", Stall_Count, 1);
      tick(); IDEX_MemRead = 1'b1; IDEX_Rt = 5'd0; IFID_Rs = 5'd0;
      mid(); chk("lu_r0_pcw", PC_Write, 1);

      // taken branch, two flush cycles
      tick(); idle(); Branch_Taken = 1'b1;
      mid(); chk("br_fl0", IFID_Flush, 1); chk("br_bub0", IDEX_Bubble, 1);
      tick(); idle();
      mid(); chk("br_fl1", IFID_Flush, 1); chk("br_bub1", IDEX_Bubble, 0); chk("br_st1", State, 2);
      tick();
      mid(); chk("br_fl2", IFID_Flush, 0); chk("br_st2", State, 0); chk("br_cnt", Stall_Count, 3);

      // jump
      tick(); Jump = 1'b1;
      mid(); chk("jmp_fl", IFID_Flush, 1); chk("jmp_pcw", PC_Write, 1);
      tick(); idle();

      // three-cycle memory stall
      Mem_Req = 1'b1; Mem_Ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         mid(); chk("mem_hold", Pipe_Hold, 1);
         tick();
      end
      Mem_Ready = 1'b1;
      mid(); chk("mem_rdy_hold", Pipe_Hold, 0); chk("mem_rdy_st", State, 1);
      tick(); idle();
      mid(); chk("mem_st", State, 0); chk("mem_cnt", Stall_Count, 7); chk("mem_err0", Mem_Err, 0);

      // timeout after the fourth wait cycle
      tick(); Mem_Req = 1'b1; Mem_Ready = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         mid();
         if (i == 4) chk("to_err_pre", Mem_Err, 0);
         if (i == 5) chk("to_err_set", Mem_Err, 1);
         tick();
      end
      idle();
      mid(); chk("to_rdy_pcw", PC_Write, 1);
      tick();
      mid(); chk("to_err_sticky", Mem_Err, 1); chk("to_st", State, 0); chk("to_cnt", Stall_Count, 13);

      // memory stall outranks branch and load-use
      tick(); Mem_Req = 1'b1; Mem_Ready = 1'b0; Branch_Taken = 1'b1;
      IDEX_MemRead = 1'b1; IDEX_Rt = 5'd7; IFID_Rt = 5'd7;
      mid(); chk("pri_fl", IFID_Flush, 0); chk("pri_bub", IDEX_Bubble, 0); chk("pri_hold", Pipe_Hold, 1);
      tick(); idle();
      tick();
      mid(); chk("pri_st", State, 0); chk("pri_cnt", Stall_Count, 14);

      // memory stall during redirect freezes it
      tick(); Branch_Taken = 1'b1;
      tick(); idle(); Mem_Req = 1'b1; Mem_Ready = 1'b0;
      mid(); chk("rdm_hold", Pipe_Hold, 1); chk("rdm_fl", IFID_Flush, 0); chk("rdm_st", State, 2);
      tick(); idle();
      mid(); chk("rdm_fl2", IFID_Flush, 1); chk("rdm_st2", State, 2);
      tick();
      mid(); chk("rdm_st3", State, 0); chk("rdm_cnt", Stall_Count, 17);

      // asynchronous reset in the middle of a redirect
      tick(); Branch_Taken = 1'b1;
      tick(); idle();
      #2; rst_n = 1'b0; model_reset();
      #1; chk("ar_st", State, 0); chk("ar_cnt", Stall_Count, 0);
      chk("ar_fl", IFID_Flush, 0); chk("ar_pcw", PC_Write, 1); chk("ar_err", Mem_Err, 0);
      tick(); rst_n = 1'b1;

      // long stall saturates the lost-cycle counter
      Mem_Req = 1'b1; Mem_Ready = 1'b0;
      repeat (70) tick();
      mid(); chk("sat_cnt", Stall_Count, CMAX); chk("sat_err", Mem_Err, 1);
      tick(); idle();
      tick();

      // randomized traffic with occasional asynchronous resets
      for (int i = 0; i < 3000; i++) begin
         tick();
         rst_n = 1'b1;
         IFID_Rs      = 5'($urandom_range(0, 3));
         IFID_Rt      = 5'($urandom_range(0, 3));
         IDEX_Rt      = 5'($urandom_range(0, 3));
         IDEX_MemRead = ($urandom_range(0, 1) == 1);
         Branch_Taken = ($urandom_range(0, 6) == 0);
         Jump         = ($urandom_range(0, 6) == 0);
         Mem_Req      = ($urandom_range(0, 3) == 0);
         Mem_Ready    = ($urandom_range(0, 4) > 1);
         if ($urandom_range(0, 199) == 0) begin
            #2; rst_n = 1'b0; model_reset();
         end
      end
      tick(); rst_n = 1'b1; idle();
      tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 The block SHALL have parameter BR_PENALTY, default 2, meaning fetch-redirect cycles (IF/ID flushes) after a taken branch; legal range 1..7.
REQ-002 The block SHALL have parameter MEM_TIMEOUT, default 255, meaning maximum MEM_WAIT cycles before Mem_Err sets; legal range 1..255.
REQ-003 The block SHALL have parameter CNT_W, default 16, meaning Stall_Count width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 IFID_Rs, IFID_Rt  input  5 each  source registers of the instruction in ID.
REQ-007 IDEX_Rt, IDEX_MemRead  input  5, 1  destination and load flag of the instruction in EX.
REQ-008 Branch_Taken  input  1  branch resolved taken in EX this cycle.
REQ-009 Jump  input  1  jump decoded in ID this cycle.
REQ-010 Mem_Req, Mem_Ready  input  1, 1  data-memory access in MEM and its completion.
REQ-011 PC_Write, IFID_Write  output  1, 1  enables for PC and IF/ID registers.
REQ-012 IFID_Flush, IDEX_Bubble  output  1, 1  zero IF/ID contents; load NOP control into ID/EX.
REQ-013 Pipe_Hold  output  1  freezes ID/EX, EX/MEM and MEM/WB.
REQ-014 State  output  2  current FSM state: RUN=0, MEM_WAIT=1, REDIRECT=2.
REQ-015 Stall_Count  output  CNT_W  lost-cycle counter; Mem_Err  output  1  sticky memory-timeout flag.

Function
REQ-016 Outputs SHALL be combinational from the registered state and current inputs; next-state, counters and Mem_Err SHALL update on clk rising edge.
REQ-017 Default (no condition active): PC_Write=1, IFID_Write=1, IFID_Flush=0, IDEX_Bubble=0, Pipe_Hold=0.
REQ-018 Load-use SHALL be detected as IDEX_MemRead && IDEX_Rt!=0 && (IDEX_Rt==IFID_Rs || IDEX_Rt==IFID_Rt).
REQ-019 RUN priority SHALL be: memory stall > Branch_Taken > load-use > Jump; only the highest active condition acts.
REQ-020 RUN, Mem_Req && !Mem_Ready: PC_Write=0, IFID_Write=0, Pipe_Hold=1; next state MEM_WAIT; wait counter loads 1.
REQ-021 RUN, Branch_Taken: IFID_Flush=1, IDEX_Bubble=1, PC_Write=1; if BR_PENALTY>1 next REDIRECT with redirect counter = BR_PENALTY-1, else stay RUN.
REQ-022 RUN, load-use: PC_Write=0, IFID_Write=0, IDEX_Bubble=1 for exactly that cycle; stay RUN.
REQ-023 RUN, Jump: IFID_Flush=1 for that cycle; stay RUN.
REQ-024 MEM_WAIT: outputs as REQ-020 while !Mem_Ready; wait counter increments (saturating at 255); on Mem_Ready, default outputs that cycle and return to RUN.
REQ-025 MEM_WAIT: when wait counter reaches MEM_TIMEOUT with Mem_Ready low, Mem_Err SHALL set and remain set until reset; the FSM stays in MEM_WAIT.
REQ-026 REDIRECT: IFID_Flush=1, PC_Write=1; counter decrements; at counter==1 return to RUN; Branch_Taken, Jump, load-use ignored.
REQ-027 REDIRECT with Mem_Req && !Mem_Ready SHALL apply REQ-020 outputs, freeze the redirect counter and stay REDIRECT until Mem_Ready.
REQ-028 Stall_Count SHALL increment by 1 each cycle PC_Write==0 or IFID_Flush==1, saturating at 2^CNT_W-1 (no wrap).

Reset
REQ-029 rst_n low SHALL immediately force State=RUN, redirect and wait counters 0, Stall_Count=0, Mem_Err=0, regardless of clk, including mid-MEM_WAIT or mid-REDIRECT.
REQ-030 During reset outputs SHALL equal REQ-017 defaults; first post-reset edge evaluates RUN.

Verification
REQ-031 Load-use: IDEX_MemRead=1, IDEX_Rt=5, IFID_Rs=5 one cycle -> PC_Write=0, IFID_Write=0, IDEX_Bubble=1 that cycle only; Stall_Count 0->1; IDEX_Rt=0 same case -> no stall.
REQ-032 Branch, BR_PENALTY=2: Branch_Taken pulse -> IFID_Flush=1 two consecutive cycles, IDEX_Bubble=1 first cycle only, State 0->2->0, Stall_Count +2.
REQ-033 Memory stall: Mem_Req=1, Mem_Ready low 3 cycles then high -> Pipe_Hold=1 for 3 cycles, State=1 during, RUN after, Stall_Count +3, Mem_Err=0.
REQ-034 Timeout, MEM_TIMEOUT=4: Mem_Ready held low 6 cycles -> Mem_Err=1 after 4th wait cycle, stays 1 after Mem_Ready returns.
REQ-035 Simultaneous: Mem stall + Branch_Taken + load-use same cycle -> only memory stall acts (IFID_Flush=0, IDEX_Bubble=0).
REQ-036 Reset mid-REDIRECT: rst_n low between edges -> State=0, Stall_Count=0 immediately, outputs default.
